// File: rtl/spike_encoder_pkg.sv
// spike_encoder shared types and constants.
// State encoding, LFSR toggle mask and default seed.
package spike_encoder_pkg;

  typedef enum logic [1:0] {
    IDLE,
    GEN,
    HOLD,
    DONE
  } state_t;

  localparam logic [15:0] LFSR_MASK    = 16'hB400;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

endpackage

// File: rtl/lfsr16.sv
// 16-bit right-shifting Galois LFSR, x^16+x^14+x^13+x^11+1.
// load has priority over en; reset restores SEED.
module lfsr16
  import spike_encoder_pkg::*;
#(
  parameter logic [15:0] SEED = DEFAULT_SEED
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        load,
  input  logic [15:0] seed,
  output logic [15:0] q
);

  // Shift register: reload on load, one Galois step on en.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= SEED;
    end else if (load) begin
      q <= seed;
    end else if (en) begin
      q <= {1'b0, q[15:1]} ^ (q[0] ? LFSR_MASK : 16'h0000);
    end
  end

endmodule

// File: rtl/spike_encoder.sv
// Rate-coding spike encoder: per-channel intensity vs LFSR sample.
// Macro SPIKE_ENCODER_RESEED_EN reloads the LFSR seed on each start.
module spike_encoder
  import spike_encoder_pkg::*;
#(
  parameter int          S_WIDTH   = 8,
  parameter int          I_WIDTH   = 8,
  parameter int          T_STEPS   = 16,
  parameter logic [15:0] LFSR_SEED = DEFAULT_SEED,
  localparam int AW = (S_WIDTH > 1) ? $clog2(S_WIDTH) : 1,
  localparam int TW = (T_STEPS > 1) ? $clog2(T_STEPS) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               pix_we,
  input  logic [AW-1:0]      pix_addr,
  input  logic [I_WIDTH-1:0] pix_in,
  output logic [S_WIDTH-1:0] spike_vec,
  output logic               spike_valid,
  input  logic               spike_ready,
  output logic [TW-1:0]      step,
  output logic               busy,
  output logic               done
);

  state_t state, state_nx;

  logic [AW-1:0]      ch;
  logic [I_WIDTH-1:0] pix_buf [S_WIDTH];
  logic [15:0]        lfsr;
  logic [15:0]        sample;
  logic               last_ch;
  logic               last_step;
  logic               accept;
  logic               take;
  logic               fire;
  logic               reseed;

  assign last_ch   = (32'(ch) == S_WIDTH - 1);
  assign last_step = (32'(step) == T_STEPS - 1);
  assign accept    = (state == IDLE) && start;
  assign take      = (state == HOLD) && spike_ready;
  assign sample    = lfsr >> (16 - I_WIDTH);
  assign fire      = 16'(pix_buf[ch]) > sample;

`ifdef SPIKE_ENCODER_RESEED_EN
  assign reseed = accept;
`else
  assign reseed = 1'b0;
`endif

  lfsr16 #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .en   (state == GEN),
    .load (reseed),
    .seed (LFSR_SEED),
    .q    (lfsr)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = GEN;
      GEN:     if (last_ch) state_nx = HOLD;
      HOLD:    if (spike_ready) state_nx = last_step ? DONE : GEN;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Counters, spike vector and registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ch          <= '0;
      step        <= '0;
      spike_vec   <= '0;
      spike_valid <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      spike_valid <= (state_nx == HOLD);
      busy        <= (state_nx != IDLE);
      done        <= (state_nx == DONE);
      if (accept) begin
        ch        <= '0;
        step      <= '0;
        spike_vec <= '0;
      end else if (state == GEN) begin
        spike_vec[ch] <= fire;
        ch            <= ch + 1'b1;
      end else if (take && !last_step) begin
        step      <= step + 1'b1;
        ch        <= '0;
        spike_vec <= '0;
      end
    end
  end

  // Intensity buffer, writable only while idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < S_WIDTH; i++) pix_buf[i] <= '0;
    end else if (state == IDLE && pix_we && 32'(pix_addr) < S_WIDTH) begin
      pix_buf[pix_addr] <= pix_in;
    end
  end

endmodule

// File: tb/tb_spike_encoder.sv
// Directed bench for spike_encoder (default parameters).
// Software LFSR model supplies every expected spike vector.
module tb_spike_encoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       pix_we;
  logic [2:0] pix_addr;
  logic [7:0] pix_in;
  logic [7:0] spike_vec;
  logic       spike_valid;
  logic       spike_ready;
  logic [3:0] step;
  logic       busy;
  logic       done;

  int total = 0;
  int bad   = 0;
  int dc;

  logic [15:0] m;
  logic [7:0]  img [8];
  logic [7:0]  fv  [16];
  logic [7:0]  va  [16];

  always #5 clk = ~clk;

  spike_encoder dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .pix_we      (pix_we),
    .pix_addr    (pix_addr),
    .pix_in      (pix_in),
    .spike_vec   (spike_vec),
    .spike_valid (spike_valid),
    .spike_ready (spike_ready),
    .step        (step),
    .busy        (busy),
    .done        (done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] want);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  task automatic model_vec(output logic [7:0] v);
    for (int c = 0; c < 8; c++) begin
      v[c] = img[c] > m[15:8];
      m = m[0] ? ((m >> 1) ^ 16'hB400) : (m >> 1);
    end
  endtask

  task automatic wr(input int a, input logic [7:0] d);
    pix_we   = 1'b1;
    pix_addr = 3'(a);
    pix_in   = d;
    tick();
    pix_we   = 1'b0;
    img[a]   = d;
  endtask

  task automatic run_frame(input int stall_at, input int poke_at);
    logic [7:0] ev;
    int nv;
    int st;
    nv = 0;
    st = 0;
    dc = -1;
`ifdef SPIKE_ENCODER_RESEED_EN
    m = 16'hACE1;
`endif
    start = 1'b1;
    spike_ready = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_after_start", 32'(busy), 1);
    for (int cyc = 1; cyc <= 400; cyc++) begin
      if (done) begin
        dc = cyc;
        break;
      end
      if (st > 0 || spike_valid) begin
        if (st == 0) begin
          model_vec(ev);
          chk("vec", 32'(spike_vec), 32'(ev));
          chk("vec_step", 32'(step), nv);
          fv[nv[3:0]] = spike_vec;
        end else begin
          chk("bp_valid", 32'(spike_valid), 1);
          chk("bp_vec", 32'(spike_vec), 32'(fv[nv[3:0]]));
          chk("bp_step", 32'(step), nv);
        end
        if (nv == stall_at && st < 5) begin
          spike_ready = 1'b0;
          st++;
        end else begin
          spike_ready = 1'b1;
          nv++;
          st = 0;
        end
      end
      if (cyc == poke_at) begin
        start    = 1'b1;
        pix_we   = 1'b1;
        pix_addr = 3'd3;
        pix_in   = 8'h80;
      end else begin
        start  = 1'b0;
        pix_we = 1'b0;
      end
      tick();
    end
    start  = 1'b0;
    pix_we = 1'b0;
    chk("nvec", nv, 16);
    chk("done_cyc", dc, (stall_at >= 0) ? 150 : 145);
    chk("done_step", 32'(step), 15);
    tick();
    chk("done_pulse", 32'(done), 0);
    chk("idle_busy", 32'(busy), 0);
    chk("idle_step", 32'(step), 15);
  endtask

  initial begin
    int same;
    int found;
    rst         = 1'b1;
    start       = 1'b0;
    pix_we      = 1'b0;
    pix_addr    = '0;
    pix_in      = '0;
    spike_ready = 1'b0;
    m           = 16'hACE1;
    for (int i = 0; i < 8; i++) img[i] = 8'h00;
    tick();
    tick();
    chk("rst_vec", 32'(spike_vec), 0);
    chk("rst_valid", 32'(spike_valid), 0);
    chk("rst_step", 32'(step), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    rst = 1'b0;
    tick();

    // all-zero intensities
    run_frame(-1, -1);

    // all-max intensities
    for (int i = 0; i < 8; i++) wr(i, 8'hFF);
    run_frame(-1, -1);

    // backpressure in step 4
    run_frame(4, -1);

    // start / pix_we pulsed mid-frame are ignored
    run_frame(-1, 20);
    wr(3, 8'h80);
    run_frame(-1, -1);

    // two back-to-back frames on the same image
    wr(0, 8'h00); wr(1, 8'h20); wr(2, 8'h40); wr(3, 8'h60);
    wr(4, 8'h80); wr(5, 8'hA0); wr(6, 8'hC0); wr(7, 8'hFF);
    run_frame(-1, -1);
    for (int i = 0; i < 16; i++) va[i] = fv[i];
    run_frame(-1, -1);
    same = 1;
    for (int i = 0; i < 16; i++) if (va[i] !== fv[i]) same = 0;
`ifdef SPIKE_ENCODER_RESEED_EN
    chk("reseed_same", same, 1);
`else
    chk("reseed_same", same, 0);
`endif

    // reset in HOLD of step 7
    start = 1'b1;
    spike_ready = 1'b1;
    tick();
    start = 1'b0;
    found = 0;
    for (int k = 0; k < 400; k++) begin
      if (spike_valid && step == 4'd7) begin
        found = 1;
        break;
      end
      tick();
    end
    chk("reach_step7", found, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_vec", 32'(spike_vec), 0);
    chk("mid_rst_valid", 32'(spike_valid), 0);
    chk("mid_rst_step", 32'(step), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_done", 32'(done), 0);
    tick();
    rst = 1'b0;
    tick();
    m = 16'hACE1;
    for (int i = 0; i < 8; i++) img[i] = 8'h00;
    run_frame(-1, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
